// File: rtl/histogram_reduce.sv
// Histogram reduce stage: adds one completed per-frame bank into the global
// accumulated histogram, tracking the per-frame total and a sticky overflow.
module histogram_reduce #(
   parameter int NBINS = 256,
   parameter int AW    = 8,
   parameter int DW    = 32
) (
   input  logic          ap_clk,
   input  logic          ap_rst_n,
   input  logic          ap_start,
   output logic          ap_done,
   input  logic          ap_continue,
   output logic          ap_idle,
   output logic          ap_ready,
   input  logic          acc_clear,
   output logic [AW-1:0] hist_address0,
   output logic          hist_ce0,
   input  logic [DW-1:0] hist_q0,
   output logic [AW-1:0] acc_address0,
   output logic          acc_ce0,
   input  logic [DW-1:0] acc_q0,
   output logic [AW-1:0] acc_address1,
   output logic          acc_ce1,
   output logic          acc_we1,
   output logic [DW-1:0] acc_d1,
   output logic [DW-1:0] frame_total,
   output logic          ovf
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN
   } state_t;

   localparam logic [AW-1:0] LAST_IDX = AW'(NBINS - 1);

   state_t        state, state_nxt;
   logic          done_reg;
   logic          accept;
   logic [AW-1:0] idx;
   logic [AW-1:0] addr_d;
   logic          valid_d;
   logic          clr_q;
   logic [DW:0]   bin_sum;
   logic [DW:0]   tot_sum;

   // NOTE: every output of this block is given a default first, so no path
   // through the case statement can leave a signal unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      ap_done   = done_reg;
      ap_ready  = 1'b0;
      ap_idle   = 1'b0;
      hist_ce0  = 1'b0;
      acc_ce0   = 1'b0;
      case (state)
         S_IDLE: begin
            ap_idle = ~ap_start;
            if (ap_start && !done_reg) begin
               accept    = 1'b1;
               state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            hist_ce0 = 1'b1;
            acc_ce0  = 1'b1;
            if (idx == LAST_IDX) state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            ap_done   = 1'b1;
            ap_ready  = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign hist_address0 = idx;
   assign acc_address0  = idx;

   // Write side trails the read side by one cycle, matching the memory latency.
   assign bin_sum      = {1'b0, acc_q0} + {1'b0, hist_q0};
   assign tot_sum      = {1'b0, frame_total} + {1'b0, hist_q0};
   assign acc_ce1      = valid_d;
   assign acc_we1      = valid_d;
   assign acc_address1 = addr_d;
   assign acc_d1       = !valid_d ? '0 : (clr_q ? hist_q0 : bin_sum[DW-1:0]);

   // NOTE: state registers use non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state       <= S_IDLE;
         done_reg    <= 1'b0;
         idx         <= '0;
         addr_d      <= '0;
         valid_d     <= 1'b0;
         clr_q       <= 1'b0;
         frame_total <= '0;
         ovf         <= 1'b0;
      end else begin
         state <= state_nxt;

         if (accept) begin
            idx         <= '0;
            clr_q       <= acc_clear;
            frame_total <= '0;
         end

         if (state == S_RUN) begin
            valid_d <= 1'b1;
            addr_d  <= idx;
            idx     <= idx + AW'(1);
         end else begin
            valid_d <= 1'b0;
         end

         if (valid_d) begin
            frame_total <= tot_sum[DW-1:0];
            ovf         <= ovf | (~clr_q & bin_sum[DW]) | tot_sum[DW];
         end

         // Done is held for downstream unless it acknowledges in the same cycle.
         if (state == S_DRAIN)  done_reg <= ~ap_continue;
         else if (ap_continue)  done_reg <= 1'b0;
      end
   end

endmodule
